// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule tables, widths, state encoding and rotate helpers
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;

  // Tables use DES 1-based bit numbering, bit 1 being the MSB of the source word.
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef enum logic [1:0] {IDLE, LOADED, RUN, DONE} ks_state_t;

  function automatic logic [55:0] pc1(input logic [KEY_W-1:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = key[6'(64 - PC1_TBL[i])];
    end
    return r;
  endfunction

  // Round r is 1-based; true when that round rotates by two positions.
  function automatic logic shift_is_two(input logic [4:0] r);
    return SHIFT_SCHED[4'(r - 5'd1)] == 2;
  endfunction

  function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// rtl/des_key_schedule_if.sv - load/round control and subkey result bundle for the key schedule
interface des_key_schedule_if #(
  parameter int IDX_BITS = 5
);
  logic                key_load;
  logic [63:0]         key_in;
  logic                ed_sel;
  logic                round_en;
  logic [47:0]         subkey;
  logic                subkey_valid;
  logic [IDX_BITS-1:0] round_idx;
  logic                last_round;
  logic                parity_err;

  modport master (
    output key_load, key_in, ed_sel, round_en,
    input  subkey, subkey_valid, round_idx, last_round, parity_err
  );

  modport slave (
    input  key_load, key_in, ed_sel, round_en,
    output subkey, subkey_valid, round_idx, last_round, parity_err
  );
endinterface

// File: rtl/des_pc2_perm.sv
// rtl/des_pc2_perm.sv - combinational PC-2 permutation, 56-bit C||D to 48-bit subkey
module des_pc2_perm
  import des_pkg::*;
(
  input  logic [55:0]         cd,
  output logic [SUBKEY_W-1:0] subkey
);

  logic unused_dropped_bits;

  // PC-2 discards DES bits 9, 18, 22, 25, 35, 38, 43 and 54 of C||D.
  assign unused_dropped_bits = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - DES round-subkey generator; byte parity check under DES_KEY_PARITY_CHECK_EN
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16,
  parameter int IDX_BITS   = 5
) (
  input logic               clk,
  input logic               n_rst,
  des_key_schedule_if.slave ks
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_LOADED = LOADED;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_DONE   = DONE;

  logic [1:0]          state_q;
  logic                mode_q;
  logic [CD_W-1:0]     c_q, d_q;
  logic [CD_W-1:0]     c_nxt, d_nxt;
  logic [CD_W-1:0]     c_store, d_store;
  logic [IDX_BITS-1:0] idx_q, k;
  logic [SUBKEY_W-1:0] subkey_q, subkey_nxt;
  logic                valid_q, last_q;
  logic                advance, final_rnd, two_l, two_r;
  logic [55:0]         pc1_key;

  assign pc1_key   = pc1(ks.key_in);
  assign k         = idx_q + IDX_BITS'(1);
  assign final_rnd = (k == IDX_BITS'(NUM_ROUNDS));
  assign two_l     = shift_is_two(5'(k));
  assign two_r     = shift_is_two(5'd18 - 5'(k));
  assign advance   = ks.round_en && !ks.key_load &&
                     ((state_q == ST_LOADED) || (state_q == ST_RUN));

  always_comb begin
    c_nxt = c_q;
    d_nxt = d_q;
    if (!mode_q) begin
      c_nxt = rotl28(c_q, two_l);
      d_nxt = rotl28(d_q, two_l);
    end else if (k != IDX_BITS'(1)) begin
      c_nxt = rotr28(c_q, two_r);
      d_nxt = rotr28(d_q, two_r);
    end
    c_store = c_nxt;
    d_store = d_nxt;
    // Decrypt rotations total 27; one more right step parks C/D back on the PC-1 value.
    if (mode_q && final_rnd) begin
      c_store = rotr28(c_nxt, 1'b0);
      d_store = rotr28(d_nxt, 1'b0);
    end
  end

  des_pc2_perm u_pc2 (
    .cd     ({c_nxt, d_nxt}),
    .subkey (subkey_nxt)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      c_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      subkey_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      last_q <= 1'b0;
      if (ks.key_load) begin
        c_q     <= pc1_key[55:28];
        d_q     <= pc1_key[27:0];
        mode_q  <= ks.ed_sel;
        idx_q   <= '0;
        valid_q <= 1'b0;
        state_q <= ST_LOADED;
      end else if (advance) begin
        c_q      <= c_store;
        d_q      <= d_store;
        subkey_q <= subkey_nxt;
        valid_q  <= 1'b1;
        idx_q    <= k;
        if (final_rnd) begin
          state_q <= ST_DONE;
          last_q  <= 1'b1;
        end else begin
          state_q <= ST_RUN;
        end
      end
    end
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic parity_q;
  logic key_even_byte;

  always_comb begin
    key_even_byte = 1'b0;
    for (int b = 0; b < 8; b++) begin
      key_even_byte = key_even_byte | ~(^ks.key_in[b*8 +: 8]);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_q <= 1'b0;
    end else if (ks.key_load) begin
      parity_q <= key_even_byte;
    end
  end

  assign ks.parity_err = parity_q;
`else
  logic unused_parity_bits;

  assign unused_parity_bits = ^{ks.key_in[56], ks.key_in[48], ks.key_in[40], ks.key_in[32],
                                ks.key_in[24], ks.key_in[16], ks.key_in[8],  ks.key_in[0]};
  assign ks.parity_err = 1'b0;
`endif

  assign ks.subkey       = subkey_q;
  assign ks.subkey_valid = valid_q;
  assign ks.round_idx    = idx_q;
  assign ks.last_round   = last_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - self-checking bench for des_key_schedule with a reference key-schedule model
module tb_des_key_schedule;

  logic clk;
  logic n_rst;
  int   errors;
  int   checks;

  des_key_schedule_if #(.IDX_BITS(5)) ksif ();

  des_key_schedule #(.NUM_ROUNDS(16), .IDX_BITS(5)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .ks    (ksif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] sk;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  exp_t sbq[$];

  int m_pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int m_pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int m_sh [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] m_ks [16];
  logic [55:0] m_cd0;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  // Reference schedule: K1..K16 by cumulative left rotation from the PC-1 value.
  task automatic m_gen(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk;
    cd = '0;
    for (int i = 0; i < 56; i++) cd = {cd[54:0], key[6'(64 - m_pc1_t[i])]};
    m_cd0 = cd;
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      c = (c << m_sh[r]) | (c >> (28 - m_sh[r]));
      d = (d << m_sh[r]) | (d >> (28 - m_sh[r]));
      cd = {c, d};
      sk = '0;
      for (int i = 0; i < 48; i++) sk = {sk[46:0], cd[6'(56 - m_pc2_t[i])]};
      m_ks[r] = sk;
    end
  endtask

  function automatic logic m_par(input logic [63:0] key);
    logic bad;
    int   n;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      n = 0;
      for (int j = 0; j < 8; j++) n += int'(key[6'(b * 8 + j)]);
      if (n % 2 == 0) bad = 1'b1;
    end
    return bad;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] key, input logic ed);
    ksif.key_in   = key;
    ksif.ed_sel   = ed;
    ksif.key_load = 1'b1;
    tick();
    ksif.key_load = 1'b0;
  endtask

  task automatic push_round(input int k, input logic dec);
    exp_t e;
    e.sk   = dec ? m_ks[16 - k] : m_ks[k - 1];
    e.idx  = 5'(k);
    e.last = (k == 16);
    sbq.push_back(e);
    ksif.round_en = 1'b1;
    tick();
    ksif.round_en = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    ksif.key_load = 1'b0;
    ksif.key_in   = '0;
    ksif.ed_sel   = 1'b0;
    ksif.round_en = 1'b0;
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    checks++;
    if ({ksif.subkey, ksif.subkey_valid, ksif.round_idx, ksif.last_round, ksif.parity_err} !== 56'd0) begin
      errors++;
      $display("FAIL reset_outputs got sk=%h v=%b idx=%0d last=%b perr=%b required all zero",
               ksif.subkey, ksif.subkey_valid, ksif.round_idx, ksif.last_round, ksif.parity_err);
    end
    ksif.round_en = 1'b1;
    repeat (2) tick();
    ksif.round_en = 1'b0;
    checks++;
    if (ksif.subkey_valid !== 1'b0 || ksif.round_idx !== 5'd0 || ksif.subkey !== 48'd0) begin
      errors++;
      $display("FAIL idle_round_en got v=%b idx=%0d sk=%h required v=0 idx=0 sk=0",
               ksif.subkey_valid, ksif.round_idx, ksif.subkey);
    end
  endtask

  task automatic test_schedule(input logic dec);
    exp_t e;
    m_gen(KEY_A);
    do_load(KEY_A, dec);
    checks++;
    if (ksif.subkey_valid !== 1'b0 || ksif.round_idx !== 5'd0) begin
      errors++;
      $display("FAIL load_state dec=%b got v=%b idx=%0d required v=0 idx=0", dec, ksif.subkey_valid, ksif.round_idx);
    end
    for (int k = 1; k <= 16; k++) begin
      push_round(k, dec);
      e = sbq.pop_front();
      checks++;
      if (ksif.subkey !== e.sk || ksif.round_idx !== e.idx || ksif.last_round !== e.last || ksif.subkey_valid !== 1'b1) begin
        errors++;
        $display("FAIL round dec=%b k=%0d got sk=%h idx=%0d last=%b v=%b required sk=%h idx=%0d last=%b v=1",
                 dec, k, ksif.subkey, ksif.round_idx, ksif.last_round, ksif.subkey_valid, e.sk, e.idx, e.last);
      end
      if (k == 1 || k == 16) begin
        checks++;
        if (ksif.subkey !== (((k == 1) ^ dec) ? 48'h1B02EFFC7072 : 48'hCB3D8B0E17F5)) begin
          errors++;
          $display("FAIL kat dec=%b k=%0d got sk=%h", dec, k, ksif.subkey);
        end
      end
    end
    checks++;
    if ({dut.c_q, dut.d_q} !== m_cd0) begin
      errors++;
      $display("FAIL final_cd dec=%b got %h required %h", dec, {dut.c_q, dut.d_q}, m_cd0);
    end
    tick();
    checks++;
    if (ksif.last_round !== 1'b0 || ksif.round_idx !== 5'd16 || ksif.subkey_valid !== 1'b1) begin
      errors++;
      $display("FAIL done_hold dec=%b got last=%b idx=%0d v=%b required last=0 idx=16 v=1",
               dec, ksif.last_round, ksif.round_idx, ksif.subkey_valid);
    end
  endtask

  task automatic test_gapped();
    exp_t        e;
    logic [47:0] prev_sk;
    m_gen(KEY_A);
    do_load(KEY_A, 1'b0);
    prev_sk = ksif.subkey;
    for (int k = 1; k <= 16; k++) begin
      repeat (2) tick();
      checks++;
      if (ksif.subkey !== prev_sk || ksif.round_idx !== 5'(k - 1)) begin
        errors++;
        $display("FAIL gap_hold k=%0d got sk=%h idx=%0d required sk=%h idx=%0d",
                 k, ksif.subkey, ksif.round_idx, prev_sk, k - 1);
      end
      push_round(k, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (ksif.subkey !== e.sk || ksif.round_idx !== e.idx) begin
        errors++;
        $display("FAIL gap_round k=%0d got sk=%h idx=%0d required sk=%h idx=%0d",
                 k, ksif.subkey, ksif.round_idx, e.sk, e.idx);
      end
      prev_sk = e.sk;
    end
    for (int x = 0; x < 5; x++) begin
      ksif.round_en = 1'b1;
      tick();
      ksif.round_en = 1'b0;
      checks++;
      if (ksif.round_idx !== 5'd16 || ksif.subkey !== m_ks[15] || ksif.subkey_valid !== 1'b1 || ksif.last_round !== 1'b0) begin
        errors++;
        $display("FAIL extra_en x=%0d got idx=%0d sk=%h v=%b last=%b required idx=16 sk=%h v=1 last=0",
                 x, ksif.round_idx, ksif.subkey, ksif.subkey_valid, ksif.last_round, m_ks[15]);
      end
    end
  endtask

  task automatic test_load_collision();
    exp_t e;
    m_gen(KEY_A);
    do_load(KEY_A, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      push_round(k, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (ksif.subkey !== e.sk) begin
        errors++;
        $display("FAIL coll_pre k=%0d got sk=%h required %h", k, ksif.subkey, e.sk);
      end
    end
    ksif.key_in   = KEY_B;
    ksif.ed_sel   = 1'b0;
    ksif.key_load = 1'b1;
    ksif.round_en = 1'b1;
    tick();
    ksif.key_load = 1'b0;
    ksif.round_en = 1'b0;
    checks++;
    if (ksif.round_idx !== 5'd0 || ksif.subkey_valid !== 1'b0 || ksif.subkey !== m_ks[5]) begin
      errors++;
      $display("FAIL coll_load got idx=%0d v=%b sk=%h required idx=0 v=0 sk=%h",
               ksif.round_idx, ksif.subkey_valid, ksif.subkey, m_ks[5]);
    end
    m_gen(KEY_B);
    push_round(1, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (ksif.subkey !== e.sk || ksif.round_idx !== 5'd1 || ksif.subkey_valid !== 1'b1) begin
      errors++;
      $display("FAIL coll_k1 got sk=%h idx=%0d v=%b required sk=%h idx=1 v=1",
               ksif.subkey, ksif.round_idx, ksif.subkey_valid, e.sk);
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    m_gen(KEY_A);
    do_load(KEY_A, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      push_round(k, 1'b1);
      e = sbq.pop_front();
    end
    checks++;
    if (ksif.subkey !== e.sk || ksif.round_idx !== 5'd8) begin
      errors++;
      $display("FAIL pre_reset got sk=%h idx=%0d required sk=%h idx=8", ksif.subkey, ksif.round_idx, e.sk);
    end
    n_rst = 1'b0;
    #2;
    checks++;
    if ({ksif.subkey, ksif.subkey_valid, ksif.round_idx, ksif.last_round, ksif.parity_err} !== 56'd0 ||
        {dut.c_q, dut.d_q} !== 56'd0 || dut.state_q !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got sk=%h v=%b idx=%0d cd=%h st=%0d required all zero",
               ksif.subkey, ksif.subkey_valid, ksif.round_idx, {dut.c_q, dut.d_q}, dut.state_q);
    end
    tick();
    n_rst = 1'b1;
    ksif.round_en = 1'b1;
    repeat (3) tick();
    ksif.round_en = 1'b0;
    checks++;
    if (ksif.round_idx !== 5'd0 || ksif.subkey_valid !== 1'b0 || ksif.subkey !== 48'd0) begin
      errors++;
      $display("FAIL post_reset_en got idx=%0d v=%b sk=%h required idx=0 v=0 sk=0",
               ksif.round_idx, ksif.subkey_valid, ksif.subkey);
    end
    do_load(KEY_A, 1'b0);
    push_round(1, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (ksif.subkey !== e.sk || ksif.round_idx !== 5'd1) begin
      errors++;
      $display("FAIL reload_k1 got sk=%h idx=%0d required sk=%h idx=1", ksif.subkey, ksif.round_idx, e.sk);
    end
  endtask

  task automatic test_parity();
    logic [63:0] keys [5];
    logic        exp_p;
    keys[0] = KEY_A;
    keys[1] = 64'h0101010101010101;
    keys[2] = 64'h0000000000000000;
    keys[3] = KEY_B;
    keys[4] = 64'h0101010101010100;
    for (int i = 0; i < 5; i++) begin
      do_load(keys[i], 1'b0);
`ifdef DES_KEY_PARITY_CHECK_EN
      exp_p = m_par(keys[i]);
`else
      exp_p = 1'b0;
`endif
      checks++;
      if (ksif.parity_err !== exp_p) begin
        errors++;
        $display("FAIL parity key=%h got %b required %b", keys[i], ksif.parity_err, exp_p);
      end
      repeat (2) tick();
      checks++;
      if (ksif.parity_err !== exp_p) begin
        errors++;
        $display("FAIL parity_hold key=%h got %b required %b", keys[i], ksif.parity_err, exp_p);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_schedule(1'b0);
    test_schedule(1'b1);
    test_gapped();
    test_load_collision();
    test_reset_midrun();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
